byte_to_word_loader: RTL and testbench

Assembles a stream of received bytes (e.g. from the UART receiver) into 32-bit little-endian words and writes them sequentially into a word-addressed memory such as instruction or data RAM. It is the write-side counterpart of the byte-read path: byte address N maps to word N>>2, lane N[1:0]. It handles the valid/ready byte handshake, the byte-address counter, partial-word flush and end-of-memory detection. It sits between the UART byte receiver and the memory write port during programming mode.

---
 rtl/byte_to_word_loader.sv | 137 +++++++++++++
 tb/tb_byte_to_word_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_to_word_loader.sv
// byte_to_word_loader: packs a byte stream into 32-bit little-endian
// words and writes them to a word-addressed memory during programming.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start, flush    begin a load at byte 0 / end the load early
//   byte_valid/byte_ready/byte_data   byte handshake
//   word_we/word_addr_out/word_data_out  memory write port
//   byte_count      bytes accepted, saturating at 2^BYTE_ADDR_WIDTH
//   busy, done      load in progress / load finished pulse
module byte_to_word_loader #(
  parameter int BYTE_ADDR_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         flush,
  input  logic                         byte_valid,
  output logic                         byte_ready,
  input  logic [7:0]                   byte_data,
  output logic                         word_we,
  output logic [BYTE_ADDR_WIDTH-3:0]   word_addr_out,
  output logic [31:0]                  word_data_out,
  output logic [BYTE_ADDR_WIDTH:0]     byte_count,
  output logic                         busy,
  output logic                         done
);

  localparam int AW = BYTE_ADDR_WIDTH;
  localparam logic [AW:0] CMAX = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_ptr;
  logic [AW:0]     r_count;
  logic [31:0]     r_asm;
  logic [31:0]     r_data;
  logic [AW-3:0]   r_addr;
  // Set on entry to WRITE when the load must finish after this word.
  logic            r_end;

  logic            w_acc;
  logic [AW-1:0]   w_ptr_nxt;
  logic [31:0]     w_merged;

  always_comb begin
    w_acc     = (r_state == S_LOAD) && byte_valid;
    w_ptr_nxt = r_ptr + (w_acc ? AW'(1) : AW'(0));
    w_merged  = r_asm;
    if (w_acc) begin
      unique case (r_ptr[1:0])
        2'd0: w_merged[7:0]   = byte_data;
        2'd1: w_merged[15:8]  = byte_data;
        2'd2: w_merged[23:16] = byte_data;
        2'd3: w_merged[31:24] = byte_data;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (start)
          w_state_nxt = S_LOAD;
        else if (w_acc && (r_ptr[1:0] == 2'd3))
          w_state_nxt = S_WRITE;
        else if (flush)
          w_state_nxt = (w_ptr_nxt[1:0] != 2'd0) ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        if (start)
          w_state_nxt = S_LOAD;
        else
          w_state_nxt = r_end ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        w_state_nxt = start ? S_LOAD : S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_asm   <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_end   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (start) begin
        r_ptr   <= '0;
        r_count <= '0;
        r_asm   <= '0;
        r_data  <= '0;
        r_addr  <= '0;
        r_end   <= 1'b0;
      end else if (r_state == S_LOAD) begin
        r_ptr <= w_ptr_nxt;
        if (w_acc && (r_count != CMAX))
          r_count <= r_count + 1'b1;
        if (w_state_nxt == S_WRITE) begin
          // Word index comes from the pre-increment pointer so a
          // completed lane-3 word is not attributed to the next word.
          r_addr <= r_ptr[AW-1:2];
          r_data <= w_merged;
          r_asm  <= '0;
          r_end  <= flush || (w_acc && (&r_ptr));
        end else begin
          r_asm <= w_merged;
        end
      end
    end
  end

  assign byte_ready    = (r_state == S_LOAD);
  assign word_we       = (r_state == S_WRITE);
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign word_addr_out = r_addr;
  assign word_data_out = r_data;
  assign byte_count    = r_count;

endmodule

// File: tb/tb_byte_to_word_loader.sv
// Testbench for byte_to_word_loader: randomized byte streams checked
// against a little-endian memory image built from the sent bytes.
module tb_byte_to_word_loader;

  localparam int AW = 6;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          start = 0;
  logic          flush = 0;
  logic          byte_valid = 0;
  logic          byte_ready;
  logic [7:0]    byte_data = 0;
  logic          word_we;
  logic [AW-3:0] word_addr_out;
  logic [31:0]   word_data_out;
  logic [AW:0]   byte_count;
  logic          busy;
  logic          done;

  int n_pass = 0;
  int n_total = 0;

  logic [35:0] wr_q[$];
  logic [7:0]  sent[$];

  byte_to_word_loader #(.BYTE_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_data(byte_data), .word_we(word_we),
    .word_addr_out(word_addr_out), .word_data_out(word_data_out),
    .byte_count(byte_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (word_we === 1'b1)
      wr_q.push_back({word_addr_out, word_data_out});

  // Reference image: byte i lives in word i/4 at bit offset 8*(i%4).
  function automatic logic [31:0] exp_word(input int k);
    logic [31:0] w;
    w = 0;
    for (int j = 0; j < 4; j++)
      if (4 * k + j < sent.size())
        w = w | (32'(sent[4 * k + j]) << (8 * j));
    return w;
  endfunction

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
    wr_q.delete();
    sent.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    byte_valid = 1;
    byte_data = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_total++;
      $display("FAIL send_timeout: byte_ready never rose, want 1");
    end
    @(negedge clk);
    sent.push_back(b);
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_total++;
    if (done !== 1'b1)
      $display("FAIL %s_done: got %b want 1", nm, done);
    else n_pass++;
  endtask

  task automatic cmp_image(input string nm, input int nw);
    n_total++;
    if (wr_q.size() !== nw)
      $display("FAIL %s_nwrites: got %0d want %0d", nm, wr_q.size(), nw);
    else n_pass++;
    for (int k = 0; k < nw && k < wr_q.size(); k++) begin
      n_total++;
      if (wr_q[k] !== {4'(k), exp_word(k)})
        $display("FAIL %s_word%0d: got %h want %h", nm, k,
                 wr_q[k], {4'(k), exp_word(k)});
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_total++;
    if ({byte_ready, word_we, word_addr_out, word_data_out,
         byte_count, busy, done} !== '0)
      $display("FAIL reset_outputs: got %b%b %h %h %h %b%b want all 0",
               byte_ready, word_we, word_addr_out, word_data_out,
               byte_count, busy, done);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1;
      byte_data = 8'(i + 1);
      @(negedge clk);
    end
    byte_valid = 0;
    n_total++;
    if (wr_q.size() !== 0 || byte_count !== 0)
      $display("FAIL idle_ignore: writes %0d count %0d want 0 0",
               wr_q.size(), byte_count);
    else n_pass++;
  endtask

  task automatic test_single_word();
    pulse_start();
    n_total++;
    if (busy !== 1'b1 || byte_ready !== 1'b1)
      $display("FAIL start_ready: busy %b ready %b want 1 1",
               busy, byte_ready);
    else n_pass++;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    n_total++;
    if (word_we !== 1'b1 || byte_ready !== 1'b0 ||
        word_addr_out !== 0 || word_data_out !== 32'h44332211)
      $display("FAIL single_write: we %b rdy %b a %h d %h want 1 0 0 44332211",
               word_we, byte_ready, word_addr_out, word_data_out);
    else n_pass++;
    byte_valid = 0;
    @(negedge clk);
    n_total++;
    if (byte_ready !== 1'b1 || byte_count !== 4)
      $display("FAIL single_after: rdy %b count %0d want 1 4",
               byte_ready, byte_count);
    else n_pass++;
    flush = 1;
    @(negedge clk);
    flush = 0;
    n_total++;
    if (done !== 1'b1)
      $display("FAIL single_flush_done: got %b want 1", done);
    else n_pass++;
    cmp_image("single", 1);
  endtask

  task automatic test_full_load();
    pulse_start();
    for (int i = 0; i < 64; i++)
      send_byte(8'(i));
    n_total++;
    if (word_we !== 1'b1 || word_addr_out !== 4'd15)
      $display("FAIL full_last_we: we %b addr %0d want 1 15",
               word_we, word_addr_out);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b1 || busy !== 1'b1)
      $display("FAIL full_done: done %b busy %b want 1 1", done, busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || byte_count !== 64)
      $display("FAIL full_idle: busy %b done %b count %0d want 0 0 64",
               busy, done, byte_count);
    else n_pass++;
    repeat (5) @(negedge clk);
    byte_valid = 0;
    n_total++;
    if (byte_count !== 64 || byte_ready !== 1'b0)
      $display("FAIL full_ignore: count %0d rdy %b want 64 0",
               byte_count, byte_ready);
    else n_pass++;
    cmp_image("full", 16);
  endtask

  task automatic test_partial_flush();
    pulse_start();
    for (int i = 0; i < 6; i++)
      send_byte(8'hA0 + 8'(i));
    byte_valid = 0;
    flush = 1;
    @(negedge clk);
    flush = 0;
    wait_done("pflush");
    cmp_image("pflush", 2);
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 4; i++)
      send_byte(8'(8'h50 + i));
    byte_valid = 0;
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    wait_done("aflush");
    cmp_image("aflush", 1);
    @(negedge clk);
  endtask

  task automatic test_restart_reset();
    int n0;
    pulse_start();
    send_byte(8'hC0);
    send_byte(8'hC1);
    byte_valid = 0;
    pulse_start();
    for (int i = 0; i < 4; i++)
      send_byte(8'hB0 + 8'(i));
    send_byte(8'hD0);
    send_byte(8'hD1);
    byte_valid = 0;
    n_total++;
    if (byte_count !== 6)
      $display("FAIL restart_count: got %0d want 6", byte_count);
    else n_pass++;
    cmp_image("restart", 1);
    n0 = wr_q.size();
    #2 rst_n = 0;
    #3 rst_n = 1;
    repeat (8) @(negedge clk);
    n_total++;
    if (wr_q.size() !== n0 || busy !== 1'b0 || byte_count !== 0 ||
        word_data_out !== 0)
      $display("FAIL midreset: writes %0d busy %b cnt %0d d %h want %0d 0 0 0",
               wr_q.size(), busy, byte_count, word_data_out, n0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int n;
    int t;
    for (int r = 0; r < 3; r++) begin
      n = 20 + int'($urandom_range(0, 43));
      pulse_start();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          byte_valid = 0;
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        send_byte(8'($urandom));
      end
      byte_valid = 0;
      if (n < 64) begin
        t = 0;
        while (byte_ready !== 1'b1 && t < 10) begin
          @(negedge clk);
          t++;
        end
        flush = 1;
        @(negedge clk);
        flush = 0;
      end
      wait_done("bp");
      n_total++;
      if (byte_count !== 7'(n))
        $display("FAIL bp_count: got %0d want %0d", byte_count, n);
      else n_pass++;
      cmp_image("bp", (n + 3) / 4);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_load();
    test_partial_flush();
    test_restart_reset();
    test_backpressure();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
